// File: rtl/mem_pkg.sv
// Shared types for the data-memory responder: FSM states, op encoding, word width.
package mem_pkg;
  localparam int WORD_W = 16;

  typedef enum logic {IDLE, BUSY} state_e;
  typedef enum logic {OP_RD, OP_WR} op_e;
endpackage

// File: rtl/mem_array.sv
// Single-port synchronous word array; write and read both take effect on the clock edge.
// Reset clears only the read-data register; stored contents survive reset.
module mem_array
  import mem_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic                  re,
  input  logic [DEPTH_LOG2-1:0] idx,
  input  logic [WORD_W-1:0]     wdata,
  output logic [WORD_W-1:0]     rdata
);

  logic [WORD_W-1:0] r_mem [0:(1 << DEPTH_LOG2) - 1];
  logic [WORD_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[idx] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (re) begin
      r_rdata <= r_mem[idx];
    end
  end

  assign rdata = r_rdata;

endmodule

// File: rtl/mem_resp.sv
// Fixed-latency handshaked data memory: accepts one request in IDLE, stalls while in flight,
// pulses Done on completion; both-requests and odd addresses set a sticky err.
module mem_resp
  import mem_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Rd,
  input  logic              Wr,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [WORD_W-1:0] DataIn,
  output logic [WORD_W-1:0] DataOut,
  output logic              Done,
  output logic              Stall,
  output logic              err
);

  localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  state_e              r_state;
  state_e              w_state_nxt;
  logic [3:0]          r_cnt;
  logic [3:0]          w_cnt_nxt;
  op_e                 r_op;
  logic [DEPTH_LOG2:0] r_addr;
  logic [WORD_W-1:0]   r_data;
  logic                r_done;
  logic                r_err;

  logic                w_accept;
  logic                w_conflict;
  logic                w_exec;
  op_e                 w_exec_op;
  logic [DEPTH_LOG2:0] w_exec_addr;
  logic [WORD_W-1:0]   w_exec_data;
  logic                w_unaligned;
  logic                w_we;
  logic                w_re;

  assign w_accept   = (r_state == IDLE) && (Rd ^ Wr);
  assign w_conflict = (r_state == IDLE) && Rd && Wr;

  // With single-cycle latency the accepted request executes straight from the ports.
  assign w_exec      = (LATENCY == 1) ? w_accept : ((r_state == BUSY) && (r_cnt == 4'd0));
  assign w_exec_op   = (LATENCY == 1) ? (Wr ? OP_WR : OP_RD) : r_op;
  assign w_exec_addr = (LATENCY == 1) ? Addr[DEPTH_LOG2:0] : r_addr;
  assign w_exec_data = (LATENCY == 1) ? DataIn : r_data;
  assign w_unaligned = w_exec_addr[0];

  assign w_we = !rst && w_exec && !w_unaligned && (w_exec_op == OP_WR);
  assign w_re = !rst && w_exec && !w_unaligned && (w_exec_op == OP_RD);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_accept && (LATENCY > 1)) begin
          w_state_nxt = BUSY;
          w_cnt_nxt   = CNT_INIT;
        end
      end
      BUSY: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    Stall = (r_state == BUSY);
    Done  = r_done;
    err   = r_err;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op   <= OP_RD;
      r_addr <= '0;
      r_data <= '0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op   <= Wr ? OP_WR : OP_RD;
        r_addr <= Addr[DEPTH_LOG2:0];
        r_data <= DataIn;
      end
      r_done <= w_exec;
      if (w_conflict || (w_exec && w_unaligned)) begin
        r_err <= 1'b1;
      end
    end
  end

  mem_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clk  (clk),
    .rst  (rst),
    .we   (w_we),
    .re   (w_re),
    .idx  (w_exec_addr[DEPTH_LOG2:1]),
    .wdata(w_exec_data),
    .rdata(DataOut)
  );

endmodule

// File: tb/tb_mem_resp.sv
// Directed bench for mem_resp at latencies 1, 2 and 4 (instances 0, 1, 2).
module tb_mem_resp;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd   [3];
  logic        wr   [3];
  logic [15:0] addr [3];
  logic [15:0] din  [3];
  logic [15:0] dout [3];
  logic        done [3];
  logic        stall[3];
  logic        err  [3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_resp #(.LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .Rd(rd[0]), .Wr(wr[0]), .Addr(addr[0]), .DataIn(din[0]),
    .DataOut(dout[0]), .Done(done[0]), .Stall(stall[0]), .err(err[0]));
  mem_resp #(.LATENCY(2)) u_l2 (
    .clk(clk), .rst(rst), .Rd(rd[1]), .Wr(wr[1]), .Addr(addr[1]), .DataIn(din[1]),
    .DataOut(dout[1]), .Done(done[1]), .Stall(stall[1]), .err(err[1]));
  mem_resp #(.LATENCY(4)) u_l4 (
    .clk(clk), .rst(rst), .Rd(rd[2]), .Wr(wr[2]), .Addr(addr[2]), .DataIn(din[2]),
    .DataOut(dout[2]), .Done(done[2]), .Stall(stall[2]), .err(err[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      rd[k] = 1'b0; wr[k] = 1'b0;
    end
    tick(); tick();
    rst = 1'b0;
  endtask

  // Holds the request until Done appears (bounded), then releases it in the Done cycle.
  task automatic run_req(input int k, input logic w, input logic [15:0] a,
                         input logic [15:0] d, output logic [15:0] rdat);
    int n;
    n = 0;
    rd[k] = !w; wr[k] = w; addr[k] = a; din[k] = d;
    do begin
      tick();
      n++;
    end while (!done[k] && n < 20);
    check("req_done", {31'd0, done[k]}, 32'd1);
    rdat = dout[k];
    rd[k] = 1'b0; wr[k] = 1'b0;
  endtask

  logic [15:0] l1_addr [8] = '{16'h0, 16'h0, 16'h2, 16'h2, 16'h0, 16'h0, 16'h2, 16'h2};
  logic [15:0] l1_data [8] = '{16'h1234, 16'h0, 16'h5678, 16'h0, 16'h5678, 16'h0, 16'h1234, 16'h0};
  logic [15:0] l1_exp  [8] = '{16'h0, 16'h1234, 16'h0, 16'h5678, 16'h0, 16'h5678, 16'h0, 16'h1234};

  logic [15:0] rdat;

  initial begin
    for (int k = 0; k < 3; k++) begin
      rd[k] = 1'b0; wr[k] = 1'b0; addr[k] = '0; din[k] = '0;
    end
    do_reset();

    for (int k = 0; k < 3; k++) begin
      check("rst_done",  {31'd0, done[k]},  32'd0);
      check("rst_stall", {31'd0, stall[k]}, 32'd0);
      check("rst_err",   {31'd0, err[k]},   32'd0);
      check("rst_dout",  {16'd0, dout[k]},  32'h0);
    end

    // Latency 2: write then back-to-back read in the Done cycle.
    wr[1] = 1'b1; addr[1] = 16'h0010; din[1] = 16'hBEEF;
    tick();
    check("l2_w_stall1", {31'd0, stall[1]}, 32'd1);
    check("l2_w_done1",  {31'd0, done[1]},  32'd0);
    tick();
    check("l2_w_done2",  {31'd0, done[1]},  32'd1);
    check("l2_w_stall2", {31'd0, stall[1]}, 32'd0);
    wr[1] = 1'b0; rd[1] = 1'b1;
    tick();
    check("l2_r_stall3", {31'd0, stall[1]}, 32'd1);
    check("l2_r_done3",  {31'd0, done[1]},  32'd0);
    tick();
    check("l2_r_done4",  {31'd0, done[1]},  32'd1);
    check("l2_r_data4",  {16'd0, dout[1]},  32'hBEEF);
    rd[1] = 1'b0;
    tick();
    check("l2_r_done5",  {31'd0, done[1]},  32'd0);
    check("l2_r_hold5",  {16'd0, dout[1]},  32'hBEEF);

    // Latency 1: a request every cycle, each Done in the following cycle.
    for (int i = 0; i < 8; i++) begin
      wr[0] = (i % 2 == 0); rd[0] = (i % 2 == 1);
      addr[0] = l1_addr[i]; din[0] = l1_data[i];
      tick();
      check("l1_done",  {31'd0, done[0]},  32'd1);
      check("l1_stall", {31'd0, stall[0]}, 32'd0);
      if (i % 2 == 1) check("l1_rdata", {16'd0, dout[0]}, {16'd0, l1_exp[i]});
    end
    rd[0] = 1'b0; wr[0] = 1'b0;
    tick();
    check("l1_idle_done", {31'd0, done[0]}, 32'd0);

    // Latency 1: address bits above the array index alias onto low addresses.
    run_req(0, 1'b1, 16'h0800, 16'h9ABC, rdat);
    run_req(0, 1'b0, 16'h0000, 16'h0000, rdat);
    check("alias_rdata", {16'd0, rdat}, 32'h9ABC);
    check("alias_err",   {31'd0, err[0]}, 32'd0);

    // Latency 4: held read with address changed mid-stall.
    run_req(2, 1'b1, 16'h0040, 16'h1111, rdat);
    run_req(2, 1'b1, 16'h0080, 16'h2222, rdat);
    rd[2] = 1'b1; addr[2] = 16'h0040;
    tick();
    check("l4_stall1", {31'd0, stall[2]}, 32'd1);
    addr[2] = 16'h0080;
    for (int c = 2; c <= 3; c++) begin
      tick();
      check("l4_stall", {31'd0, stall[2]}, 32'd1);
      check("l4_nodone", {31'd0, done[2]}, 32'd0);
    end
    tick();
    check("l4_done4", {31'd0, done[2]}, 32'd1);
    check("l4_data4", {16'd0, dout[2]}, 32'h1111);
    rd[2] = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      check("l4_no_second_done", {31'd0, done[2]},  32'd0);
      check("l4_no_second_stall", {31'd0, stall[2]}, 32'd0);
    end

    // Both requests at once: sticky err, no acceptance.
    rd[1] = 1'b1; wr[1] = 1'b1; addr[1] = 16'h0010;
    tick();
    rd[1] = 1'b0; wr[1] = 1'b0;
    check("conf_err",   {31'd0, err[1]},   32'd1);
    check("conf_done",  {31'd0, done[1]},  32'd0);
    check("conf_stall", {31'd0, stall[1]}, 32'd0);
    for (int c = 0; c < 10; c++) begin
      tick();
      check("conf_err_hold", {31'd0, err[1]},  32'd1);
      check("conf_no_done",  {31'd0, done[1]}, 32'd0);
    end
    do_reset();
    check("conf_err_clr", {31'd0, err[1]}, 32'd0);

    // Unaligned write: completes normally, suppressed, flags err at execute.
    wr[1] = 1'b1; addr[1] = 16'h0011; din[1] = 16'hAAAA;
    tick();
    check("ua_stall1", {31'd0, stall[1]}, 32'd1);
    check("ua_err1",   {31'd0, err[1]},   32'd0);
    tick();
    wr[1] = 1'b0;
    check("ua_done2",  {31'd0, done[1]},  32'd1);
    check("ua_err2",   {31'd0, err[1]},   32'd1);
    check("ua_dout2",  {16'd0, dout[1]},  32'h0);
    run_req(1, 1'b0, 16'h0010, 16'h0000, rdat);
    check("ua_prior", {16'd0, rdat}, 32'hBEEF);
    check("ua_err_hold", {31'd0, err[1]}, 32'd1);

    // Reset while a write is in flight abandons it.
    do_reset();
    run_req(1, 1'b1, 16'h0020, 16'h1357, rdat);
    wr[1] = 1'b1; addr[1] = 16'h0020; din[1] = 16'hCAFE;
    tick();
    wr[1] = 1'b0; rst = 1'b1;
    tick();
    check("abort_done_rst", {31'd0, done[1]},  32'd0);
    check("abort_stall",    {31'd0, stall[1]}, 32'd0);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("abort_no_done", {31'd0, done[1]}, 32'd0);
    end
    run_req(1, 1'b0, 16'h0020, 16'h0000, rdat);
    check("abort_rdata", {16'd0, rdat}, 32'h1357);
    check("abort_err",   {31'd0, err[1]}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_resp.md
Name: mem_resp

Overview:
- Data-memory responder for the processor's memory stage. It replaces the ideal single-cycle data memory with a fixed-latency, handshaked word memory.
- It accepts one read or write request at a time, asserts Stall while the request is in flight, and pulses Done when the request completes. Read data is returned with Done.
- It flags protocol and alignment errors on a sticky err output, which the processor top ORs into its own err.

Parameters:
- ADDR_W, 16, byte-address width.
- DEPTH_LOG2, 10, log2 of the number of 16-bit words stored; words are indexed by Addr[DEPTH_LOG2:1].
- LATENCY, 2, cycles from request to Done; legal range 1..15.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset, synchronous and active-high.
- Rd  input  1  read request.
- Wr  input  1  write request.
- Addr  input  ADDR_W  byte address; must be even.
- DataIn  input  16  write data.
- DataOut  output  16  read data; valid while Done=1 for a read; holds its value otherwise.
- Done  output  1  one-cycle completion pulse.
- Stall  output  1  high while a request is in flight and new requests are ignored.
- err  output  1  sticky error flag.

Behaviour:
- Reset:
  - Takes effect at the rising edge while rst=1.
  - State goes to IDLE; counter=0; Done=0; Stall=0; DataOut=16'h0000; err=0.
  - Array contents are not cleared.
  - Reset mid-operation abandons the pending request: no write is committed and Done is not asserted.
- States: IDLE and BUSY, plus a 4-bit counter cnt.
- Accept rule:
  - In IDLE, exactly one of Rd/Wr high in cycle c means the request is accepted at the end of c.
  - Addr, DataIn and the operation are latched at acceptance.
- LATENCY=1:
  - The operation executes at the end of c.
  - Done=1 in cycle c+1; Stall is never asserted.
- LATENCY>1:
  - Accept moves to BUSY with cnt=LATENCY-2.
  - Stall=1 in cycles c+1..c+LATENCY-1.
  - In BUSY with cnt=0, the operation executes at the end of that cycle and the block returns to IDLE; Done=1 in cycle c+LATENCY.
  - Otherwise cnt decrements.
- Execute step:
  - Write: mem[addr_l[DEPTH_LOG2:1]] <= data_l.
  - Read: DataOut <= mem[addr_l[DEPTH_LOG2:1]].
  - Done is registered, pulses for exactly one cycle, and is high for reads and writes alike.
- Back-to-back: the Done cycle is in IDLE, so a new request in that cycle is accepted.
  - A read accepted in the Done cycle of a write to the same address returns the new data.
- Requests while Stall=1 are ignored; they are neither queued nor errored. The initiator holds Rd/Wr until it sees Done.
- Rd and Wr both high in IDLE: the request is not accepted; err<=1 at the end of that cycle; no Done.
- Unaligned access (Addr[0]=1 when accepted):
  - The request is accepted and times out normally; Done is pulsed.
  - Writes are suppressed and DataOut is unchanged.
  - err<=1 at the execute edge.
- Address bits above DEPTH_LOG2 are ignored (aliasing). This is not an error.
- err stays high until rst.
- Rd=Wr=0 in IDLE: nothing happens; outputs hold.

Decomposition:
- Package mem_pkg:
  - State enum {IDLE, BUSY}.
  - Localparam WORD_W=16.
  - Op encoding {OP_RD, OP_WR}.
- Sub-module mem_array: single-port synchronous 2^DEPTH_LOG2 x 16 array with we, idx, wdata, re and a registered rdata. mem_resp holds the FSM, the counter, the request latches and err.

Test Plan:
- LATENCY=2: Wr=1, Addr=16'h0010, DataIn=16'hBEEF in cycle 0 -> Stall=1 in cycle 1; Done=1 in cycle 2. Then Rd=1 at 16'h0010 in cycle 2 -> Stall=1 in cycle 3; Done=1 and DataOut=16'hBEEF in cycle 4.
- LATENCY=1: alternate writes and reads of 16'h1234 and 16'h5678 to addresses 0x0 and 0x2 every cycle -> Stall never asserted; each read returns the matching value one cycle later.
- LATENCY=4: Rd held high for 4 cycles while Stall=1, with Addr changed mid-stall -> exactly one Done, in cycle 4, with data from the originally latched address; no second acceptance.
- Rd=Wr=1 in IDLE -> err=1 next cycle, no Done. err stays 1 across 10 idle cycles and clears only after rst.
- Wr to Addr=16'h0011 with 16'hAAAA -> Done after LATENCY cycles and err=1. A following read of 16'h0010 returns its prior value.
- Write 16'hCAFE to 0x20 accepted, rst asserted at cycle 1 -> Done never pulses. A read of 0x20 after reset returns the pre-write value.
